// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 one-wire transmitter.
package ws2812_pkg;

  localparam int unsigned T0H        = 20;
  localparam int unsigned T1H        = 40;
  localparam int unsigned T_BIT      = 63;
  localparam int unsigned T_LATCH    = 2800;
  localparam int unsigned T_UNDERRUN = 200;
  localparam int unsigned PIXEL_W    = 24;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LATCH = 2'd3
  } tx_state_t;

  // Widens a 4-bit colour choice to a full 8-bit channel.
  function automatic logic [7:0] expand4to8(input logic [3:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// NRZ bit shaper: high phase length depends on the bit value, bit_end marks the last cycle of a period.
module ws2812_bit_gen #(
  parameter int unsigned T0H   = ws2812_pkg::T0H,
  parameter int unsigned T1H   = ws2812_pkg::T1H,
  parameter int unsigned T_BIT = ws2812_pkg::T_BIT,
  parameter int unsigned CYC_W = $clog2(T_BIT)
) (
  input  logic [CYC_W-1:0] cyc,
  input  logic             bit_val,
  output logic             dout_c,
  output logic             bit_end_c
);

  assign dout_c    = cyc < CYC_W'(bit_val ? T1H : T0H);
  assign bit_end_c = cyc == CYC_W'(T_BIT - 1);

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial driver: streams 24-bit GRB words MSB first, then holds the line low for the latch gap.
module ws2812_tx #(
  parameter int unsigned T0H        = ws2812_pkg::T0H,
  parameter int unsigned T1H        = ws2812_pkg::T1H,
  parameter int unsigned T_BIT      = ws2812_pkg::T_BIT,
  parameter int unsigned T_LATCH    = ws2812_pkg::T_LATCH,
  parameter int unsigned T_UNDERRUN = ws2812_pkg::T_UNDERRUN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_last,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);
  import ws2812_pkg::*;

  localparam int unsigned CYC_W = $clog2(T_BIT);
  localparam int unsigned LAT_W = $clog2(T_LATCH);
  localparam int unsigned GAP_W = $clog2(T_UNDERRUN);

  tx_state_t        state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  pixel_t           word_q, word_d;
  logic             last_q, last_d;
  logic             under_d;
  logic             accept_c;
  logic [23:0]      bits_c;
  logic             bit_c;
  logic             high_c;
  logic             bit_end_c;

  // pixel_ready is only high where an accept must load a fresh word.
  assign accept_c = pixel_valid & pixel_ready;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_idx_d = bit_idx_q;
    lat_d     = lat_q;
    gap_d     = gap_q;
    word_d    = word_q;
    last_d    = last_q;
    under_d   = 1'b0;
    bits_c    = '0;
    bit_c     = 1'b0;
    if (accept_c) begin
      word_d    = pixel_t'(pixel_data);
      last_d    = pixel_last;
      bit_idx_d = 5'd23;
      cyc_d     = '0;
      state_d   = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cyc_q == CYC_W'(T_BIT - 1)) begin
            cyc_d = '0;
            if (bit_idx_q != 5'd0) begin
              bit_idx_d = bit_idx_q - 5'd1;
            end else if (last_q) begin
              state_d = LATCH;
              lat_d   = '0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(T_UNDERRUN - 1)) begin
            under_d = 1'b1;
            state_d = LATCH;
            lat_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        LATCH: begin
          if (lat_q == LAT_W'(T_LATCH - 1)) begin
            state_d = IDLE;
            lat_d   = '0;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
    bits_c = word_d;
    bit_c  = bits_c[bit_idx_d];
  end

  // Shaped on next-cycle values so registered dout rises the cycle after accept.
  ws2812_bit_gen #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT),
    .CYC_W (CYC_W)
  ) u_bit_gen (
    .cyc       (cyc_d),
    .bit_val   (bit_c),
    .dout_c    (high_c),
    .bit_end_c (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_idx_q   <= '0;
      lat_q       <= '0;
      gap_q       <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      dout        <= 1'b0;
      pixel_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_idx_q   <= bit_idx_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      word_q      <= word_d;
      last_q      <= last_d;
      dout        <= (state_d == SHIFT) & high_c;
      pixel_ready <= (state_d == IDLE) | (state_d == GAP) |
                     ((state_d == SHIFT) & bit_end_c & (bit_idx_d == 5'd0) & ~last_d);
      busy        <= state_d != IDLE;
      frame_done  <= (state_d == LATCH) & (lat_d == LAT_W'(T_LATCH - 1));
      underrun    <= under_d;
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: waveform timing, streaming, inter-pixel gap, underrun and mid-frame reset.
module tb_ws2812_tx;
  import ws2812_pkg::*;

  localparam int MAXC = 8000;
  localparam int PIX  = 24 * int'(T_BIT);
  localparam int LAT  = int'(T_LATCH);
  localparam int S_DOUT = 0;
  localparam int S_FD   = 1;
  localparam int S_UR   = 2;

  logic        clk;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_last;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  logic d_log [MAXC];
  logic r_log [MAXC];
  logic b_log [MAXC];
  logic f_log [MAXC];
  logic u_log [MAXC];

  int n_checks = 0;
  int n_pass   = 0;

  ws2812_tx dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_data  (pixel_data),
    .pixel_last  (pixel_last),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_cycle(input int k);
    d_log[k] = dout;
    r_log[k] = pixel_ready;
    b_log[k] = busy;
    f_log[k] = frame_done;
    u_log[k] = underrun;
  endtask

  // Expected line level k cycles into a pixel word.
  function automatic logic wave(input logic [23:0] w, input int k);
    int c;
    logic [4:0] b;
    c = k % int'(T_BIT);
    b = 5'(23 - k / int'(T_BIT));
    return c < (w[b] ? int'(T1H) : int'(T0H));
  endfunction

  function automatic logic pick(input int sel, input int k);
    case (sel)
      S_DOUT:  return d_log[k];
      S_FD:    return f_log[k];
      S_UR:    return u_log[k];
      default: return b_log[k];
    endcase
  endfunction

  function automatic int count_hi(input int sel, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (pick(sel, k) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_hi(input int sel, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (pick(sel, k) === 1'b1) return k;
    return -1;
  endfunction

  // Presents a word once pixel_ready is seen; returns in the first cycle after the accept edge.
  task automatic send(input logic [23:0] w, input logic l);
    int t = 0;
    while (pixel_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    pixel_data  = w;
    pixel_last  = l;
    pixel_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({dout, pixel_ready, busy, frame_done, underrun} !== 5'b0)
        $display("FAIL reset_outputs cycle %0d: got %b, want 00000", i,
                 {dout, pixel_ready, busy, frame_done, underrun});
      else n_pass++;
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (pixel_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, want 1", pixel_ready);
    else n_pass++;
    n_checks++;
    if ({dout, busy} !== 2'b00) $display("FAIL reset_release_dout_busy: got %b, want 00", {dout, busy});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [23:0] w = 24'h800001;
    int n = PIX + LAT;
    int errs = 0;
    send(w, 1'b1);
    pixel_valid = 1'b0;
    pixel_data  = 24'h5A5A5A;
    pixel_last  = 1'b0;
    for (int k = 0; k <= n; k++) begin
      log_cycle(k);
      if (k < n) step();
    end
    for (int k = 0; k <= n; k++) if (d_log[k] !== ((k < PIX) ? wave(w, k) : 1'b0)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL single_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if (count_hi(S_DOUT, 0, 62) != 40) $display("FAIL single_bit23_high: got %0d, want 40", count_hi(S_DOUT, 0, 62));
    else n_pass++;
    n_checks++;
    if (count_hi(S_DOUT, 11 * 63, 12 * 63 - 1) != 20)
      $display("FAIL single_bit12_high: got %0d, want 20", count_hi(S_DOUT, 11 * 63, 12 * 63 - 1));
    else n_pass++;
    n_checks++;
    if (count_hi(S_DOUT, 23 * 63, PIX - 1) != 40)
      $display("FAIL single_bit0_high: got %0d, want 40", count_hi(S_DOUT, 23 * 63, PIX - 1));
    else n_pass++;
    n_checks++;
    if (count_hi(S_FD, 0, n) != 1 || first_hi(S_FD, 0, n) != n - 1)
      $display("FAIL single_frame_done: count %0d at %0d, want 1 at %0d",
               count_hi(S_FD, 0, n), first_hi(S_FD, 0, n), n - 1);
    else n_pass++;
    n_checks++;
    if ({b_log[n - 1], b_log[n]} !== 2'b10)
      $display("FAIL single_busy_drop: got %b, want 10", {b_log[n - 1], b_log[n]});
    else n_pass++;
    n_checks++;
    if (r_log[PIX - 1] !== 1'b0) $display("FAIL single_last_ready_gated: got %b, want 0", r_log[PIX - 1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] w [3];
    int n = 3 * PIX + LAT;
    int idx = 1;
    int acc = 0;
    int errs = 0;
    logic acc_now;
    logic e;
    w[0] = 24'hFFFFFF;
    w[1] = 24'h000000;
    w[2] = 24'h0F0F0F;
    send(w[0], 1'b0);
    pixel_data = w[1];
    pixel_last = 1'b0;
    for (int k = 0; k <= n; k++) begin
      log_cycle(k);
      if (k < n) begin
        acc_now = pixel_valid & pixel_ready;
        if (frame_done === 1'b1) pixel_valid = 1'b0;
        step();
        if (acc_now) begin
          acc++;
          idx++;
          pixel_data = (idx < 3) ? w[idx] : 24'hA5A5A5;
          pixel_last = (idx == 2);
        end
      end
    end
    pixel_valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      e = (k < 3 * PIX) ? wave(w[k / PIX], k % PIX) : 1'b0;
      if (d_log[k] !== e) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL b2b_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if (acc != 2) $display("FAIL b2b_accepts: got %0d, want 2", acc); else n_pass++;
    n_checks++;
    if (first_hi(S_FD, 0, n) + 1 != 72 * 63 + 2800 || count_hi(S_FD, 0, n) != 1)
      $display("FAIL b2b_frame_time: got %0d (count %0d), want %0d",
               first_hi(S_FD, 0, n) + 1, count_hi(S_FD, 0, n), 72 * 63 + 2800);
    else n_pass++;
    n_checks++;
    if ({r_log[PIX - 1], r_log[3 * PIX - 1]} !== 2'b10)
      $display("FAIL b2b_end_ready: got %b, want 10", {r_log[PIX - 1], r_log[3 * PIX - 1]});
    else n_pass++;
    n_checks++;
    if (count_hi(S_UR, 0, n) != 0 || b_log[n] !== 1'b0)
      $display("FAIL b2b_underrun_busy: underrun %0d busy %b, want 0 0", count_hi(S_UR, 0, n), b_log[n]);
    else n_pass++;
  endtask

  task automatic test_gap();
    logic [23:0] a = 24'hC3A501;
    logic [23:0] b = 24'h13579B;
    int n = 2 * PIX + 100 + LAT;
    int errs = 0;
    logic e;
    send(a, 1'b0);
    pixel_valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      log_cycle(k);
      if (k == PIX + 99) begin
        pixel_data  = b;
        pixel_last  = 1'b1;
        pixel_valid = 1'b1;
      end
      if (k == PIX + 100) pixel_valid = 1'b0;
      if (k < n) step();
    end
    for (int k = 0; k <= n; k++) begin
      if (k < PIX) e = wave(a, k);
      else if (k < PIX + 100) e = 1'b0;
      else if (k < 2 * PIX + 100) e = wave(b, k - PIX - 100);
      else e = 1'b0;
      if (d_log[k] !== e) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL gap_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if (count_hi(S_DOUT, PIX, PIX + 99) != 0)
      $display("FAIL gap_low: %0d high cycles, want 0", count_hi(S_DOUT, PIX, PIX + 99));
    else n_pass++;
    n_checks++;
    if (count_hi(S_UR, 0, n) != 0) $display("FAIL gap_underrun: got %0d pulses, want 0", count_hi(S_UR, 0, n));
    else n_pass++;
    n_checks++;
    if ({r_log[PIX + 50], b_log[PIX + 50]} !== 2'b11)
      $display("FAIL gap_ready_busy: got %b, want 11", {r_log[PIX + 50], b_log[PIX + 50]});
    else n_pass++;
    n_checks++;
    if (first_hi(S_FD, 0, n) != n - 1 || count_hi(S_FD, 0, n) != 1)
      $display("FAIL gap_frame_done: at %0d, want %0d", first_hi(S_FD, 0, n), n - 1);
    else n_pass++;
  endtask

  task automatic test_underrun();
    logic [23:0] a = 24'h00FF00;
    int n = PIX + 200 + LAT;
    int errs = 0;
    send(a, 1'b0);
    pixel_valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      log_cycle(k);
      if (k < n) step();
    end
    for (int k = 0; k <= n; k++) if (d_log[k] !== ((k < PIX) ? wave(a, k) : 1'b0)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL underrun_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if (count_hi(S_UR, 0, n) != 1 || first_hi(S_UR, 0, n) != PIX + 200)
      $display("FAIL underrun_pulse: count %0d at %0d, want 1 at %0d",
               count_hi(S_UR, 0, n), first_hi(S_UR, 0, n), PIX + 200);
    else n_pass++;
    n_checks++;
    if (count_hi(S_FD, 0, n) != 1 || first_hi(S_FD, 0, n) != n - 1)
      $display("FAIL underrun_frame_done: at %0d, want %0d", first_hi(S_FD, 0, n), n - 1);
    else n_pass++;
    n_checks++;
    if ({r_log[PIX + 199], r_log[PIX + 200], b_log[n]} !== 3'b100)
      $display("FAIL underrun_ready_busy: got %b, want 100", {r_log[PIX + 199], r_log[PIX + 200], b_log[n]});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] a = 24'hABCDEF;
    logic [23:0] b = 24'h0F00F0;
    int kr = 11 * int'(T_BIT) + 10;
    int n = PIX + LAT;
    int errs = 0;
    int quiet = 0;
    send(a, 1'b1);
    pixel_valid = 1'b0;
    for (int k = 0; k <= kr; k++) begin
      log_cycle(k);
      if (k == kr) reset = 1'b1;
      step();
    end
    for (int k = 0; k <= kr; k++) if (d_log[k] !== wave(a, k)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL midreset_prefix_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if ({dout, busy, pixel_ready, frame_done} !== 4'b0)
      $display("FAIL midreset_outputs: got %b, want 0000", {dout, busy, pixel_ready, frame_done});
    else n_pass++;
    reset = 1'b0;
    step();
    for (int i = 0; i < 3000; i++) begin
      if (frame_done !== 1'b0 || dout !== 1'b0 || busy !== 1'b0) quiet++;
      step();
    end
    n_checks++;
    if (quiet != 0) $display("FAIL midreset_quiet: %0d active cycles, want 0", quiet); else n_pass++;
    send(b, 1'b1);
    pixel_valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      log_cycle(k);
      if (k < n) step();
    end
    errs = 0;
    for (int k = 0; k <= n; k++) if (d_log[k] !== ((k < PIX) ? wave(b, k) : 1'b0)) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL midreset_new_frame_wave: %0d wrong cycles, want 0", errs); else n_pass++;
    n_checks++;
    if (count_hi(S_FD, 0, n) != 1 || first_hi(S_FD, 0, n) != n - 1)
      $display("FAIL midreset_new_frame_done: at %0d, want %0d", first_hi(S_FD, 0, n), n - 1);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    pixel_last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_underrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
